// File: rtl/lsu_mem_responder.sv
// LSU data-port responder: serves DMEM and a small peripheral bank with byte-lane alignment.
// Define LSU_RESP_CYCLE_CNT_EN to include the free-running CYCLE register at peripheral offset 0x8.
module lsu_mem_responder #(
    parameter int LSU_ADDR_W   = 32,
    parameter int DMEM_DEPTH_W = 12,
    parameter int LED_W        = 16,
    parameter int SW_W         = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_p_req,
    input  logic [LSU_ADDR_W-1:0] i_p_addr,
    input  logic                  i_p_wren,
    input  logic [3:0]            i_p_bytemask,
    input  logic [31:0]           i_p_wdata,
    input  logic [SW_W-1:0]       i_sw,
    output logic [31:0]           o_p_rdata,
    output logic                  o_p_rvalid,
    output logic                  o_p_err,
    output logic [LED_W-1:0]      o_led
);
    localparam logic [1:0] REG_LED     = 2'd0;
    localparam logic [1:0] REG_SW      = 2'd1;
    localparam logic [1:0] REG_CYCLE   = 2'd2;
    localparam logic [1:0] REG_SCRATCH = 2'd3;

    logic [31:0]             dmem [2**DMEM_DEPTH_W];
    logic [31:0]             dmem_q;
    logic [LED_W-1:0]        led_q;
    logic [31:0]             scratch_q;
    logic [SW_W-1:0]         sw_meta;
    logic [SW_W-1:0]         sw_sync;
    logic [31:0]             cycle_word;

    logic [2:0]              region;
    logic                    is_dmem;
    logic                    is_periph;
    logic                    size_ok;
    logic                    misaligned;
    logic                    periph_undef;
    logic                    periph_ro;
    logic                    fault;
    logic                    wr_ok;
    logic [1:0]              lane;
    logic [1:0]              preg;
    logic [3:0]              lane_en;
    logic [31:0]             lane_data;
    logic [31:0]             lane_bits;
    logic [31:0]             periph_word;
    logic [DMEM_DEPTH_W-1:0] dmem_idx;
    logic                    unused_addr;

    // Request-stage registers: captured at the sampling edge, turned into a response one edge later.
    logic                    s1_valid;
    logic                    s1_err;
    logic                    s1_wr;
    logic                    s1_dmem;
    logic [1:0]              s1_lane;
    logic [3:0]              s1_mask;
    logic [31:0]             s1_pword;
    logic [31:0]             sel_word;
    logic [31:0]             size_bits;
    logic [31:0]             load_data;

    assign region      = i_p_addr[LSU_ADDR_W-1 -: 3];
    assign is_dmem     = (region[2:1] == 2'b10);
    assign is_periph   = (region == 3'b110);
    assign lane        = i_p_addr[1:0];
    assign preg        = i_p_addr[3:2];
    assign dmem_idx    = i_p_addr[DMEM_DEPTH_W+1:2];
    assign unused_addr = ^i_p_addr;

    assign size_ok    = (i_p_bytemask == 4'b0001) || (i_p_bytemask == 4'b0011) ||
                        (i_p_bytemask == 4'b1111);
    assign misaligned = ((i_p_bytemask == 4'b0011) && lane[0]) ||
                        ((i_p_bytemask == 4'b1111) && (lane != 2'd0));
    assign periph_ro  = (preg == REG_SW) || (preg == REG_CYCLE);

`ifdef LSU_RESP_CYCLE_CNT_EN
    logic [31:0] cycle_q;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            cycle_q <= '0;
        end else begin
            cycle_q <= cycle_q + 32'd1;
        end
    end

    assign cycle_word   = cycle_q;
    assign periph_undef = 1'b0;
`else
    assign cycle_word   = '0;
    assign periph_undef = (preg == REG_CYCLE);
`endif

    assign fault = !(is_dmem || is_periph) || !size_ok || misaligned ||
                   (is_periph && (periph_undef || (i_p_wren && periph_ro)));
    assign wr_ok = i_rst_n && i_p_req && i_p_wren && !fault;

    assign lane_en   = i_p_bytemask << lane;
    assign lane_data = i_p_wdata << {lane, 3'b000};

    always_comb begin
        lane_bits = '0;
        for (int i = 0; i < 4; i++) begin
            lane_bits[8*i +: 8] = {8{lane_en[i]}};
        end
    end

    always_comb begin
        periph_word = '0;
        case (preg)
            REG_LED:     periph_word = 32'(led_q);
            REG_SW:      periph_word = 32'(sw_sync);
            REG_CYCLE:   periph_word = cycle_word;
            REG_SCRATCH: periph_word = scratch_q;
            default:     periph_word = '0;
        endcase
    end

    // DMEM is deliberately not reset; reset still blocks writes through wr_ok.
    always_ff @(posedge i_clk) begin
        if (wr_ok && is_dmem) begin
            for (int i = 0; i < 4; i++) begin
                if (lane_en[i]) begin
                    dmem[dmem_idx][8*i +: 8] <= lane_data[8*i +: 8];
                end
            end
        end
        dmem_q <= dmem[dmem_idx];
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            s1_valid  <= 1'b0;
            s1_err    <= 1'b0;
            s1_wr     <= 1'b0;
            s1_dmem   <= 1'b0;
            s1_lane   <= '0;
            s1_mask   <= '0;
            s1_pword  <= '0;
            led_q     <= '0;
            scratch_q <= '0;
            sw_meta   <= '0;
            sw_sync   <= '0;
        end else begin
            sw_meta  <= i_sw;
            sw_sync  <= sw_meta;
            s1_valid <= i_p_req;
            if (i_p_req) begin
                s1_err   <= fault;
                s1_wr    <= i_p_wren;
                s1_dmem  <= is_dmem;
                s1_lane  <= lane;
                s1_mask  <= i_p_bytemask;
                s1_pword <= periph_word;
            end
            if (wr_ok && is_periph) begin
                if (preg == REG_LED) begin
                    led_q <= LED_W'((32'(led_q) & ~lane_bits) | (lane_data & lane_bits));
                end
                if (preg == REG_SCRATCH) begin
                    scratch_q <= (scratch_q & ~lane_bits) | (lane_data & lane_bits);
                end
            end
        end
    end

    always_comb begin
        sel_word = s1_dmem ? dmem_q : s1_pword;
        case (s1_mask)
            4'b0001: size_bits = 32'h0000_00FF;
            4'b0011: size_bits = 32'h0000_FFFF;
            default: size_bits = 32'hFFFF_FFFF;
        endcase
        load_data = (sel_word >> {s1_lane, 3'b000}) & size_bits;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            o_p_rvalid <= 1'b0;
            o_p_err    <= 1'b0;
            o_p_rdata  <= '0;
        end else begin
            o_p_rvalid <= s1_valid;
            if (s1_valid) begin
                o_p_err   <= s1_err;
                o_p_rdata <= (s1_err || s1_wr) ? 32'd0 : load_data;
            end
        end
    end

    assign o_led = led_q;
endmodule

// File: tb/tb_lsu_mem_responder.sv
// Randomized scoreboard bench for lsu_mem_responder with a byte-level reference model.
// Honours LSU_RESP_CYCLE_CNT_EN the same way as the design when modelling offset 0x8.
module tb_lsu_mem_responder;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req = 1'b0;
    logic        wren = 1'b0;
    logic [31:0] addr = '0;
    logic [3:0]  mask = '0;
    logic [31:0] wdata = '0;
    logic [15:0] sw = '0;
    logic [31:0] rdata;
    logic        rvalid;
    logic        err;
    logic [15:0] led;

    always #5 clk = ~clk;

    lsu_mem_responder dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_p_req      (req),
        .i_p_addr     (addr),
        .i_p_wren     (wren),
        .i_p_bytemask (mask),
        .i_p_wdata    (wdata),
        .i_sw         (sw),
        .o_p_rdata    (rdata),
        .o_p_rvalid   (rvalid),
        .o_p_err      (err),
        .o_led        (led)
    );

    int          checks = 0;
    int          failures = 0;
    int unsigned edge_cnt = 0;
    logic [64:0] exp_q[$];

    logic [31:0] mem_model[int];
    logic [31:0] cyc_model = '0;
    logic [31:0] scratch_model = '0;
    logic [15:0] led_model = '0;
    logic [15:0] sw_model = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
        end
    endtask

    // Reference: an access is a run of 'size' bytes starting at byte 'off' of the addressed word.
    function automatic void model_access(input logic [31:0] a, input logic w, input logic [3:0] m,
                                         input logic [31:0] d, output logic e, output logic [31:0] r);
        int          size;
        int          off;
        int          key;
        int          rsel;
        logic [31:0] word;
        size = (m == 4'b0001) ? 1 : (m == 4'b0011) ? 2 : (m == 4'b1111) ? 4 : 0;
        off  = int'(a[1:0]);
        key  = int'(a[13:2]);
        rsel = int'(a[3:2]);
        e = 1'b0;
        r = '0;
        word = '0;
        if (size == 0) e = 1'b1;
        else if ((off % size) != 0) e = 1'b1;
        else if (a[31] == 1'b0 || a[31:29] == 3'b111) e = 1'b1;
        else if (a[31:30] == 2'b10) begin
            if (mem_model.exists(key)) word = mem_model[key];
        end else begin
            case (rsel)
                0: word = 32'(led_model);
                1: if (w) e = 1'b1; else word = 32'(sw_model);
`ifdef LSU_RESP_CYCLE_CNT_EN
                2: if (w) e = 1'b1; else word = cyc_model;
`else
                2: e = 1'b1;
`endif
                default: word = scratch_model;
            endcase
        end
        if (!e) begin
            for (int k = 0; k < size; k++) begin
                if (w) word[8*(off+k) +: 8] = d[8*k +: 8];
                else   r[8*k +: 8] = word[8*(off+k) +: 8];
            end
            if (w) begin
                if (a[31:30] == 2'b10) mem_model[key] = word;
                else if (rsel == 0) led_model = word[15:0];
                else if (rsel == 3) scratch_model = word;
            end
        end
    endfunction

    task automatic issue_now(input logic [31:0] a, input logic w, input logic [3:0] m, input logic [31:0] d);
        logic        e;
        logic [31:0] r;
        req = 1'b1; addr = a; wren = w; mask = m; wdata = d;
        if (rst_n) begin
            model_access(a, w, m, d, e, r);
            exp_q.push_back({edge_cnt + 32'd2, e, r});
        end
    endtask

    task automatic issue(input logic [31:0] a, input logic w, input logic [3:0] m, input logic [31:0] d);
        @(negedge clk);
        issue_now(a, w, m, d);
    endtask

    task automatic idle();
        @(negedge clk);
        req = 1'b0; wren = 1'b0;
    endtask

    // Monitor: tracks time and the free-running counter, pops and compares each response.
    initial begin
        logic [64:0] e;
        forever begin
            @(posedge clk);
            edge_cnt++;
            if (!rst_n) begin
                cyc_model = '0; led_model = '0; scratch_model = '0;
            end else begin
                cyc_model++;
            end
            #1;
            if (rvalid) begin
                if (exp_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_rvalid actual=1 expected=0 edge=%0d", edge_cnt);
                end else begin
                    e = exp_q.pop_front();
                    check("resp_edge", edge_cnt, e[64:33]);
                    check("resp_err", 32'(err), 32'(e[32]));
                    check("resp_rdata", rdata, e[31:0]);
                    check("led", 32'(led), 32'(led_model));
                end
            end
        end
    end

    initial begin
        logic [31:0] a;
        logic [3:0]  m;
        int          kind;
        int          pick;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_rvalid", 32'(rvalid), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_led", 32'(led), 32'd0);
        check("rst_rdata", rdata, 32'd0);
        rst_n = 1'b1;
        issue_now(32'hC000_0008, 1'b0, 4'hF, '0);

        issue(32'h8000_0010, 1'b1, 4'hF, 32'hDEAD_BEEF);
        issue(32'h8000_0013, 1'b0, 4'b0001, '0);
        issue(32'h8000_0013, 1'b0, 4'b0001, '0);
        issue(32'h8000_0012, 1'b0, 4'b0011, '0);
        issue(32'h8000_0010, 1'b0, 4'hF, '0);

        issue(32'h8000_0020, 1'b1, 4'hF, 32'h1122_3344);
        issue(32'h8000_0021, 1'b1, 4'b0001, 32'h0000_00AA);
        issue(32'h8000_0020, 1'b0, 4'hF, '0);

        issue(32'h8000_0000, 1'b1, 4'hF, 32'h5566_7788);
        issue(32'h8000_0001, 1'b1, 4'b0011, 32'hFFFF_FFFF);
        issue(32'h8000_0002, 1'b1, 4'hF, 32'hFFFF_FFFF);
        issue(32'h8000_0000, 1'b0, 4'hF, '0);
        issue(32'h0000_0100, 1'b0, 4'hF, '0);
        issue(32'hE000_0000, 1'b0, 4'hF, '0);
        issue(32'h8000_0000, 1'b0, 4'b0000, '0);
        issue(32'h8000_0000, 1'b0, 4'b0101, '0);

        issue(32'hC000_0000, 1'b1, 4'hF, 32'h0001_A5A5);
        idle();
        check("led_direct", 32'(led), 32'h0000_A5A5);
        issue(32'hC000_0004, 1'b1, 4'hF, 32'h1);
        issue(32'hC000_000C, 1'b1, 4'hF, 32'hCAFE_1234);
        issue(32'hC000_000E, 1'b0, 4'b0011, '0);
        issue(32'hC000_0008, 1'b0, 4'hF, '0);
        sw = 16'h1234;
        repeat (3) idle();
        sw_model = 16'h1234;
        issue(32'hC000_0004, 1'b0, 4'hF, '0);

        for (int i = 0; i < 16; i++) issue(32'h8000_0000 | (32'(i) << 2), 1'b1, 4'hF, $urandom());
        for (int n = 0; n < 400; n++) begin
            kind = $urandom_range(0, 9);
            pick = $urandom_range(0, 7);
            m = (pick < 3) ? 4'b0001 : (pick < 5) ? 4'b0011 : (pick < 7) ? 4'b1111 : 4'($urandom_range(0, 15));
            if (kind < 6)
                a = 32'h8000_0000 | (32'($urandom_range(0, 65535)) << 14) |
                    (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
            else if (kind < 9)
                a = 32'hC000_0000 | ($urandom() & 32'h1FFF_FFF0) | 32'($urandom_range(0, 15));
            else if ($urandom_range(0, 1) == 0)
                a = $urandom() & 32'h7FFF_FFFF;
            else
                a = 32'hE000_0000 | ($urandom() & 32'h1FFF_FFFF);
            issue(a, 1'($urandom_range(0, 1)), m, $urandom());
            if ($urandom_range(0, 3) == 0) idle();
        end

        repeat (3) idle();
        @(negedge clk);
        rst_n = 1'b0;
        issue_now(32'h8000_0010, 1'b1, 4'hF, 32'hCAFE_F00D);
        @(negedge clk);
        rst_n = 1'b1; req = 1'b0; wren = 1'b0;
        check("rst_drop_rvalid0", 32'(rvalid), 32'd0);
        @(negedge clk);
        check("rst_drop_rvalid1", 32'(rvalid), 32'd0);
        issue_now(32'h8000_0010, 1'b0, 4'hF, '0);
        idle();

        for (int t = 0; t < 20 && exp_q.size() != 0; t++) @(posedge clk);
        #2;
        check("drain_pending", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/lsu_mem_responder.md
Name: lsu_mem_responder

Overview:
- Memory-side responder for the LSU data port: decodes the LSU request address and serves it.
- Serves data memory (DMEM) and a small peripheral register bank.
- Performs byte-lane alignment, so the LSU sees right-aligned read data and supplies right-aligned write data with an unshifted bytemask.
- Sits between the LSU in the MEM stage and the memory/peripheral fabric. Read data returns one cycle after the request, matching the LSU's two-stage load path.

Parameters:
- LSU_ADDR_W, 32, request address width; region decode uses the top 3 bits.
- DMEM_DEPTH_W, 12, log2 of DMEM words (4096 x 32 bit).
- LED_W, 16, width of the LED output register.
- SW_W, 16, width of the switch input.

Ports:
- i_clk  in  1  system clock, all state on posedge.
- i_rst_n  in  1  synchronous active-low reset.
- i_p_req  in  1  request valid, sampled on posedge.
- i_p_addr  in  LSU_ADDR_W  byte address.
- i_p_wren  in  1  1 = store, 0 = load.
- i_p_bytemask  in  4  unshifted size mask: 0001 byte, 0011 half, 1111 word.
- i_p_wdata  in  32  right-aligned store data.
- i_sw  in  SW_W  asynchronous switch inputs.
- o_p_rdata  out  32  right-aligned load data (raw; the LSU sign/zero-extends).
- o_p_rvalid  out  1  response strobe.
- o_p_err  out  1  access fault, qualified by o_p_rvalid.
- o_led  out  LED_W  LED register.

Behaviour:
- Reset (i_rst_n=0 at posedge):
  - o_p_rdata=0, o_p_rvalid=0, o_p_err=0, o_led=0, scratch=0, cycle counter=0, switch synchronisers=0.
  - DMEM contents are not reset.
  - A request sampled in the same cycle as reset is dropped: no write, no response.
- Region decode on i_p_addr:
  - [31]=0: PROGRAM, not served here.
  - [31:30]=10: DMEM, word index = addr[DMEM_DEPTH_W+1:2], upper bits ignored (aliasing).
  - [31:29]=110: PERIPH, offset = addr[3:0].
  - [31:29]=111: RESERVED.
- Alignment: byte index b = addr[1:0].
  - Misaligned when mask=0011 and b[0]=1, or mask=1111 and b!=0.
  - Mask 0000, or any mask other than the three legal values, is an illegal size.
- Fault set: PROGRAM, RESERVED, misaligned, illegal size, an undefined PERIPH offset, or a store to a read-only register.
  - A faulting request causes no state change.
  - Response: o_p_err=1, o_p_rdata=0.
- Store (i_p_req=1, i_p_wren=1, no fault):
  - Write commits at the sampling edge.
  - DMEM lane enables = mask << b; lane data = wdata << 8*b.
  - A response is still generated: rvalid=1, err=0, rdata=0.
- Load:
  - Synchronous read at the sampling edge.
  - o_p_rdata = selected word >> 8*b, masked to the access size (upper bits 0).
- Latency: exactly one cycle. Response outputs update at posedge N+1 for a request sampled at posedge N. Back-to-back requests are accepted every cycle with no stall.
- Output hold: o_p_rvalid is high for one cycle per request. o_p_rdata and o_p_err hold their last value until the next response.
- Read-after-write to the same word in consecutive cycles returns the new data (write at N, read sampled at N+1).
- PERIPH map (word accesses; byte/half use the same lane rules on the 32-bit register):
  - 0x0 LED: RW, low LED_W bits stored, upper bits read 0.
  - 0x4 SW: RO, i_sw through a 2-flop synchroniser, zero-extended.
  - 0x8 CYCLE: RO, 32-bit free-running counter, increments every cycle out of reset, wraps 0xFFFFFFFF -> 0. A load returns the value at the sampling edge.
  - 0xC SCRATCH: RW, 32 bits.
- Counter and synchronisers run independently of i_p_req.

Optional Feature:
- Macro: LSU_RESP_CYCLE_CNT_EN.
- Defined: the CYCLE register is present as above.
- Undefined: no counter logic; offset 0x8 is an undefined offset (load faults: err=1, rdata=0).

Test Plan:
- Reset hold 3 cycles, then release -> rvalid=0, err=0, led=0, rdata=0; the first CYCLE load issued at the first post-reset edge returns 0x00000000 (feature on).
- SW 0xDEADBEEF @0x80000010, then LB/LBU @0x80000013, LH @0x80000012, LW @0x80000010 in consecutive cycles -> rdata 0x000000DE, 0x000000DE, 0x0000DEAD, 0xDEADBEEF, each one cycle after its request, err=0.
- SB wdata=0x000000AA @0x80000021 over a word preloaded 0x11223344 -> LW reads 0x1122AA44.
- LH @0x80000001 and LW @0x80000002 stores -> err=1, rdata=0, memory unchanged. LW @0x00000100 and @0xE0000000 -> err=1.
- SW 0x0001A5A5 to 0xC0000000 -> o_led=0xA5A5 the next cycle. SW to 0xC0000004 -> err=1. i_sw=0x1234 -> LW 0xC0000004 returns 0x00001234 once the synchroniser has settled (2 cycles).
- Assert reset during a pending store -> no write (DMEM word unchanged), rvalid=0 the following cycle. Build without LSU_RESP_CYCLE_CNT_EN: LW 0xC0000008 -> err=1.
